// File: rtl/board_line_clearer_if.sv
// Board RAM and control bundle between the line clearer and the game logic / RAM.
// The master side is the clearer; the slave side is the RAM plus whoever issues start.
interface board_line_clearer_if #(
  parameter int COLS = 10
);
  logic            start;
  logic [5:0]      rdaddress;
  logic [COLS-1:0] dataIn;
  logic [5:0]      wraddress;
  logic [COLS-1:0] dataOut;
  logic            wren;
  logic            busy;
  logic            done;
  logic [5:0]      linesCleared;

  modport master (
    input  start, dataIn,
    output rdaddress, wraddress, dataOut, wren, busy, done, linesCleared
  );

  modport slave (
    output start, dataIn,
    input  rdaddress, wraddress, dataOut, wren, busy, done, linesCleared
  );
endinterface

// File: rtl/board_line_clearer.sv
// Removes full rows from the board RAM in place, scanning bottom to top,
// compacting survivors downward and zero-filling the vacated top rows.
module board_line_clearer #(
  parameter int ROWS = 40,
  parameter int COLS = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  board_line_clearer_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, CHECK, FILL, DONE} state_t;

  localparam logic [5:0]      LAST_ROW = 6'(ROWS - 1);
  localparam logic [COLS-1:0] FULL_ROW = '1;

  state_t     state_reg, state_next;
  logic [5:0] src_reg, src_next;
  logic [5:0] dst_reg, dst_next;
  logic [5:0] count_reg, count_next;
  logic [5:0] fillLeft_reg, fillLeft_next;
  logic [5:0] rdaddress_reg, rdaddress_next;
  logic [5:0] linesCleared_reg, linesCleared_next;
  logic [5:0] count_now;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg        <= IDLE;
      src_reg          <= '0;
      dst_reg          <= '0;
      count_reg        <= '0;
      fillLeft_reg     <= '0;
      rdaddress_reg    <= '0;
      linesCleared_reg <= '0;
    end else begin
      state_reg        <= state_next;
      src_reg          <= src_next;
      dst_reg          <= dst_next;
      count_reg        <= count_next;
      fillLeft_reg     <= fillLeft_next;
      rdaddress_reg    <= rdaddress_next;
      linesCleared_reg <= linesCleared_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    src_next          = src_reg;
    dst_next          = dst_reg;
    count_next        = count_reg;
    fillLeft_next     = fillLeft_reg;
    rdaddress_next    = rdaddress_reg;
    linesCleared_next = linesCleared_reg;
    count_now         = count_reg;
    bus.wren          = 1'b0;
    bus.wraddress     = dst_reg;
    bus.dataOut       = '0;
    bus.done          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next        = READ;
          src_next          = LAST_ROW;
          dst_next          = LAST_ROW;
          count_next        = '0;
          linesCleared_next = '0;
          rdaddress_next    = LAST_ROW;
        end
      end

      READ: state_next = CHECK;

      CHECK: begin
        // dst >= src always, so row src has been read before anything lands on it.
        if (bus.dataIn == FULL_ROW) begin
          count_now = count_reg + 6'd1;
        end else begin
          bus.wren    = 1'b1;
          bus.dataOut = bus.dataIn;
          if (dst_reg != 6'd0) dst_next = dst_reg - 6'd1;
        end
        count_next = count_now;
        if (src_reg == 6'd0) begin
          state_next    = FILL;
          fillLeft_next = count_now;
        end else begin
          src_next       = src_reg - 6'd1;
          rdaddress_next = src_reg - 6'd1;
          state_next     = READ;
        end
      end

      FILL: begin
        if (fillLeft_reg == 6'd0) begin
          state_next        = DONE;
          linesCleared_next = count_reg;
        end else begin
          bus.wren      = 1'b1;
          fillLeft_next = fillLeft_reg - 6'd1;
          if (dst_reg != 6'd0) dst_next = dst_reg - 6'd1;
        end
      end

      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy         = (state_reg != IDLE);
  assign bus.rdaddress    = rdaddress_reg;
  assign bus.linesCleared = linesCleared_reg;

endmodule

// File: tb/tb_board_line_clearer.sv
// Randomized and directed bench for board_line_clearer against a row-filtering
// reference model, with a behavioural registered-read board RAM.
module tb_board_line_clearer;

  localparam int ROWS = 40;
  localparam int COLS = 10;

  logic Clock;
  logic Reset;

  board_line_clearer_if #(.COLS(COLS)) bus ();

  board_line_clearer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [COLS-1:0] ram      [64];
  logic [COLS-1:0] load_img [64];
  logic [COLS-1:0] exp_img  [64];
  logic            load_req;
  int              exp_count;
  int              checks;
  int              errors;

  always @(posedge Clock) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) ram[i] <= load_img[i];
    end else if (bus.wren) begin
      ram[bus.wraddress] <= bus.dataOut;
    end
    bus.dataIn <= ram[bus.rdaddress];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: keep non-full rows in bottom-up order, stack them at the bottom.
  task automatic build_model();
    logic [COLS-1:0] kept[$];
    kept = {};
    for (int r = ROWS - 1; r >= 0; r--)
      if (load_img[r] != {COLS{1'b1}}) kept.push_back(load_img[r]);
    exp_count = ROWS - kept.size();
    for (int r = 0; r < 64; r++) exp_img[r] = load_img[r];
    for (int r = 0; r < ROWS; r++) exp_img[r] = '0;
    for (int k = 0; k < kept.size(); k++) exp_img[ROWS - 1 - k] = kept[k];
  endtask

  task automatic run_pass(input string name, input int mid_start_n, input int reset_n);
    int n, writes, busy_low, done_n, bad;
    build_model();
    @(negedge Clock); load_req = 1'b1;
    @(posedge Clock); #1 load_req = 1'b0;
    @(negedge Clock); bus.start = 1'b1;
    @(posedge Clock); #1 bus.start = 1'b0;
    n = 0; writes = 0; busy_low = 0; done_n = -1;
    while (done_n < 0 && n < 300) begin
      @(posedge Clock); #1;
      n++;
      if (n == reset_n) begin
        check({name, "_rst_wren"}, 32'(bus.wren), 32'd0);
        check({name, "_rst_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_rst_done"}, 32'(bus.done), 32'd0);
        check({name, "_rst_lines"}, 32'(bus.linesCleared), 32'd0);
        Reset = 1'b0;
        $display("pass %s: reset at edge %0d after %0d writes", name, n, writes);
        return;
      end
      if (bus.wren) begin
        if (writes < ROWS) begin
          check({name, "_wraddr"}, 32'(bus.wraddress), 32'(ROWS - 1 - writes));
          check({name, "_wrdata"}, 32'(bus.dataOut), 32'(exp_img[ROWS - 1 - writes]));
        end
        writes++;
      end
      if (!bus.busy) busy_low++;
      if (bus.done) done_n = n;
      bus.start = (n == mid_start_n);
      if (n == reset_n - 1) Reset = 1'b1;
    end
    bus.start = 1'b0;
    if (done_n < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_done_edge"}, 32'(done_n), 32'(2 * ROWS + exp_count + 1));
    check({name, "_lines"}, 32'(bus.linesCleared), 32'(exp_count));
    check({name, "_writes"}, 32'(writes), 32'(ROWS));
    check({name, "_busy_low"}, 32'(busy_low), 32'd0);
    @(posedge Clock); #1;
    check({name, "_post_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_post_done"}, 32'(bus.done), 32'd0);
    repeat (3) @(posedge Clock);
    #1;
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_held_lines"}, 32'(bus.linesCleared), 32'(exp_count));
    bad = 0;
    for (int r = 0; r < ROWS; r++) if (ram[r] !== exp_img[r]) bad++;
    check({name, "_ram_rows_bad"}, 32'(bad), 32'd0);
    $display("pass %s: lines=%0d done_edge=%0d writes=%0d", name, exp_count, done_n, writes);
  endtask

  task automatic clear_img();
    for (int r = 0; r < 64; r++) load_img[r] = '0;
  endtask

  initial begin
    checks = 0; errors = 0;
    Reset = 1'b1; bus.start = 1'b0; load_req = 1'b0;
    clear_img();
    repeat (3) @(posedge Clock);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_wren", 32'(bus.wren), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_lines", 32'(bus.linesCleared), 32'd0);
    check("reset_rdaddr", 32'(bus.rdaddress), 32'd0);
    check("reset_wraddr", 32'(bus.wraddress), 32'd0);
    check("reset_dataout", 32'(bus.dataOut), 32'd0);
    Reset = 1'b0;

    clear_img();
    for (int r = 0; r < ROWS; r++) load_img[r] = COLS'(r + 1);
    run_pass("no_full", -1, -1);

    clear_img();
    load_img[39] = 10'h3FF; load_img[38] = 10'h001;
    run_pass("bottom_full", -1, -1);

    clear_img();
    load_img[39] = 10'h3FF; load_img[37] = 10'h3FF;
    load_img[38] = 10'h0F0; load_img[36] = 10'h00F;
    run_pass("non_adjacent", -1, -1);

    clear_img();
    for (int r = 0; r < ROWS; r++) load_img[r] = 10'h3FF;
    run_pass("all_full_midstart", 10, -1);

    clear_img();
    for (int r = 0; r < ROWS; r++) load_img[r] = 10'h3FF;
    run_pass("all_full_reset", -1, 90);

    clear_img();
    load_img[0] = 10'h3FF;
    run_pass("top_full", -1, -1);

    for (int t = 0; t < 8; t++) begin
      clear_img();
      for (int r = 0; r < ROWS; r++)
        load_img[r] = ($urandom_range(0, 2) == 0) ? 10'h3FF : 10'($urandom);
      run_pass($sformatf("random%0d", t), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
